// File: rtl/count_event_monitor.sv
// Watches a counter's output and queues wrap-up, wrap-down and load-jump events,
// each with a timestamp, in a small show-ahead FIFO that has a valid/ready head.
module count_event_monitor #(
  parameter int CW    = 4,
  parameter int DEPTH = 4,
  parameter int TSW   = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [CW-1:0]            count,
  input  logic                     clr,
  input  logic                     ev_ready,
  output logic                     ev_valid,
  output logic [1:0]               ev_type,
  output logic [CW-1:0]            ev_value,
  output logic [TSW-1:0]           ev_time,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   prev_reg;
  logic [TSW-1:0]  ts_reg;
  logic [CW-1:0]   delta;
  logic            is_event;
  logic [1:0]      ev_kind;

  logic [1:0]      type_mem  [DEPTH];
  logic [CW-1:0]   value_mem [DEPTH];
  logic [TSW-1:0]  time_mem  [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            overflow_reg;

  logic            full, empty, pop, push_ok;

  // The wrap checks come first because the wraps are themselves +-1 steps mod 2^CW.
  always_comb begin
    state_next = state_reg;
    delta      = count - prev_reg;
    is_event   = 1'b0;
    ev_kind    = 2'b10;
    case (state_reg)
      UNPRIMED: state_next = TRACK;
      TRACK: begin
        if (prev_reg == {CW{1'b1}} && count == '0) begin
          is_event = 1'b1;
          ev_kind  = 2'b00;
        end else if (prev_reg == '0 && count == {CW{1'b1}}) begin
          is_event = 1'b1;
          ev_kind  = 2'b01;
        end else if (delta != '0 && delta != CW'(1) && delta != {CW{1'b1}}) begin
          is_event = 1'b1;
          ev_kind  = 2'b10;
        end
      end
      default: state_next = UNPRIMED;
    endcase
    if (clr) state_next = UNPRIMED;
  end

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign pop     = !empty && ev_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still fits.
  assign push_ok = is_event && (!full || pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= UNPRIMED;
      prev_reg     <= '0;
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clr) begin
      state_reg    <= state_next;
      prev_reg     <= '0;
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      prev_reg  <= count;
      ts_reg    <= ts_reg + TSW'(1);
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_reg + LW'(push_ok) - LW'(pop);
      if (is_event && full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clr) begin
      type_mem[wr_ptr_reg]  <= ev_kind;
      value_mem[wr_ptr_reg] <= count;
      time_mem[wr_ptr_reg]  <= ts_reg;
    end
  end

  // Head fields are forced to zero when empty so reset and drained states read clean.
  assign ev_valid = !empty;
  assign ev_type  = ev_valid ? type_mem[rd_ptr_reg]  : '0;
  assign ev_value = ev_valid ? value_mem[rd_ptr_reg] : '0;
  assign ev_time  = ev_valid ? time_mem[rd_ptr_reg]  : '0;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed vector table plus hand-written async-reset sequence for count_event_monitor.
module tb_count_event_monitor;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] count;
  logic       clr;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_type;
  logic [3:0] ev_value;
  logic [7:0] ev_time;
  logic [2:0] level;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  count_event_monitor #(.CW(4), .DEPTH(4), .TSW(8)) dut (
    .clock(clock), .resetn(resetn), .count(count), .clr(clr), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_type(ev_type), .ev_value(ev_value), .ev_time(ev_time),
    .level(level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr;
    logic [3:0] cnt;
    logic       rdy;
    logic       v;
    logic [1:0] ty;
    logic [3:0] val;
    logic [7:0] tm;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, input int cnt, input logic r, input logic v,
                     input int ty, input int val, input int tm, input int lvl, input logic ovf);
    vec_t e;
    e.clr = c; e.cnt = 4'(cnt); e.rdy = r; e.v = v; e.ty = 2'(ty);
    e.val = 4'(val); e.tm = 8'(tm); e.lvl = 3'(lvl); e.ovf = ovf;
    vecs.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input int ty, input int val,
                           input int tm, input int lvl, input logic ovf);
    $display("%s: count=%0d clr=%0b rdy=%0b -> valid=%0b type=%0d value=%0d time=%0d level=%0d ovf=%0b",
             tag, count, clr, ev_ready, ev_valid, ev_type, ev_value, ev_time, level, overflow);
    cmp({tag, "_valid"}, int'(ev_valid), int'(v));
    cmp({tag, "_level"}, int'(level), lvl);
    cmp({tag, "_overflow"}, int'(overflow), int'(ovf));
    if (v) begin
      cmp({tag, "_type"}, int'(ev_type), ty);
      cmp({tag, "_value"}, int'(ev_value), val);
      cmp({tag, "_time"}, int'(ev_time), tm);
    end
  endtask

  task automatic step(input logic c, input int cnt, input logic r);
    clr = c; count = 4'(cnt); ev_ready = r;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // clr cnt rdy | valid type value time level ovf   (time = timestamp before the edge)
    add(0, 5, 1,  0,0,0,0, 0,0);   // priming
    add(0, 6, 1,  0,0,0,0, 0,0);
    add(0, 7, 1,  0,0,0,0, 0,0);
    add(1, 7, 1,  0,0,0,0, 0,0);   // clr: timestamp back to 0
    add(0,14, 1,  0,0,0,0, 0,0);   // priming, ts0
    add(0,15, 1,  0,0,0,0, 0,0);
    add(0, 0, 1,  1,0,0,2, 1,0);   // wrap up
    add(0, 0, 1,  0,0,0,0, 0,0);   // popped, hold
    add(0,15, 1,  1,1,15,4, 1,0);  // wrap down
    add(0,15, 1,  0,0,0,0, 0,0);
    add(0, 3, 1,  1,2,3,6, 1,0);   // 15->3 jump
    add(0, 3, 1,  0,0,0,0, 0,0);
    add(0, 9, 1,  1,2,9,8, 1,0);   // 3->9 load jump
    add(0, 9, 1,  0,0,0,0, 0,0);   // hold, no event
    add(0, 9, 1,  0,0,0,0, 0,0);
    add(0, 0, 0,  1,2,0,11, 1,0);  // fill with ready low
    add(0, 8, 0,  1,2,0,11, 2,0);
    add(0, 0, 0,  1,2,0,11, 3,0);
    add(0, 8, 0,  1,2,0,11, 4,0);
    add(0, 0, 0,  1,2,0,11, 4,1);  // dropped
    add(0, 8, 0,  1,2,0,11, 4,1);  // dropped
    add(0, 8, 1,  1,2,8,12, 3,1);  // drain in order
    add(0, 8, 1,  1,2,0,13, 2,1);
    add(0, 8, 1,  1,2,8,14, 1,1);
    add(0, 8, 1,  0,0,0,0, 0,1);
    add(1, 8, 0,  0,0,0,0, 0,0);   // clr clears overflow
    add(0, 8, 0,  0,0,0,0, 0,0);   // priming, ts0
    add(0, 0, 0,  1,2,0,1, 1,0);
    add(0, 8, 0,  1,2,0,1, 2,0);
    add(0, 0, 0,  1,2,0,1, 3,0);
    add(0, 8, 0,  1,2,0,1, 4,0);
    add(0, 0, 1,  1,2,8,2, 4,0);   // full: push + pop together
    add(0, 0, 1,  1,2,0,3, 3,0);
    add(0, 0, 1,  1,2,8,4, 2,0);
    add(0, 0, 1,  1,2,0,5, 1,0);   // new event is last
    add(0, 0, 1,  0,0,0,0, 0,0);
    add(0, 5, 0,  1,2,5,10, 1,0);
    add(0,10, 0,  1,2,5,10, 2,0);
    add(0,15, 0,  1,2,5,10, 3,0);
    add(1, 0, 1,  0,0,0,0, 0,0);   // clr beats wrap-up push and pop
    add(0, 4, 1,  0,0,0,0, 0,0);   // priming, ts0
    add(0, 4, 1,  0,0,0,0, 0,0);
    add(0,12, 1,  1,2,12,2, 1,0);
    add(0,12, 1,  0,0,0,0, 0,0);

    resetn = 1'b0; clr = 1'b0; count = 4'd0; ev_ready = 1'b0;
    #12;
    check_out("reset", 1'b0, 0, 0, 0, 0, 1'b0);
    cmp("reset_type", int'(ev_type), 0);
    cmp("reset_value", int'(ev_value), 0);
    cmp("reset_time", int'(ev_time), 0);
    #10 resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, int'(vecs[i].cnt), vecs[i].rdy);
      check_out($sformatf("row%0d", i), vecs[i].v, int'(vecs[i].ty), int'(vecs[i].val),
                int'(vecs[i].tm), int'(vecs[i].lvl), vecs[i].ovf);
    end

    // Asynchronous reset between edges with events queued.
    step(0, 3, 0);
    check_out("ar_q1", 1'b1, 2, 3, 4, 1, 1'b0);
    step(0, 7, 0);
    check_out("ar_q2", 1'b1, 2, 3, 4, 2, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_out("ar_async", 1'b0, 0, 0, 0, 0, 1'b0);
    cmp("ar_async_type", int'(ev_type), 0);
    cmp("ar_async_value", int'(ev_value), 0);
    cmp("ar_async_time", int'(ev_time), 0);
    @(posedge clock);
    #1;
    check_out("ar_held", 1'b0, 0, 0, 0, 0, 1'b0);
    resetn = 1'b1;
    step(0, 9, 1);
    check_out("ar_prime", 1'b0, 0, 0, 0, 0, 1'b0);
    step(0, 9, 1);
    check_out("ar_hold", 1'b0, 0, 0, 0, 0, 1'b0);
    step(0, 10, 1);
    check_out("ar_step", 1'b0, 0, 0, 0, 0, 1'b0);
    step(0, 1, 1);
    check_out("ar_jump", 1'b1, 2, 1, 3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
